// File: rtl/adc_clk_divider_bank.sv
// Multi-channel divided-clock and strobe generator for the ADC timing path.
// Qualifies the PLL lock and then runs per-channel phase-aligned dividers.
module adc_clk_divider_bank #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic                    i_refclk,
  input  logic                    i_rst,
  input  logic                    i_pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] i_cfg_div,
  input  logic [NUM_CH*DIV_W-1:0] i_cfg_phase,
  input  logic                    i_cfg_load,
  input  logic [NUM_CH-1:0]       i_ch_en,
  output logic                    o_ready,
  output logic [NUM_CH-1:0]       o_clk_div,
  output logic [NUM_CH-1:0]       o_strobe,
  output logic                    o_lock_lost,
  output logic                    o_cfg_err
);

  localparam int unsigned QW = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
  // Qualify edge that sees the last of LOCK_CYCLES consecutive high samples
  localparam logic [QW-1:0] QualLast = QW'(LOCK_CYCLES - 2);

  typedef enum logic [1:0] {StWaitLock, StQualify, StRun} state_e;

  state_e                        r_state, w_state_d;
  logic [QW-1:0]                 r_qual, w_qual_d;
  logic                          r_lk_meta, r_lk_s;
  logic [NUM_CH-1:0][DIV_W-1:0]  r_div, r_phase, r_cnt, w_cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  w_cfg_div, w_cfg_phase, w_phase_nxt;
  logic [NUM_CH-1:0]             w_ch_ok, w_clk_d, w_stb_d;
  logic                          w_valid, w_accept, w_restart, w_advance;

  assign w_cfg_div   = i_cfg_div;
  assign w_cfg_phase = i_cfg_phase;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge i_refclk or negedge i_rst) begin
    if (!i_rst) begin
      r_lk_meta <= 1'b0;
      r_lk_s    <= 1'b0;
    end else begin
      r_lk_meta <= i_pll_locked;
      r_lk_s    <= r_lk_meta;
    end
  end

  // Lock supervision: next state and qualification count
  always_comb begin
    w_state_d = r_state;
    w_qual_d  = r_qual;
    unique case (r_state)
      StWaitLock: begin
        if (r_lk_s) begin
          w_state_d = StQualify;
          w_qual_d  = '0;
        end
      end
      StQualify: begin
        if (!r_lk_s) begin
          w_state_d = StWaitLock;
        end else if (r_qual == QualLast) begin
          w_state_d = StRun;
        end else begin
          w_qual_d = r_qual + QW'(1);
        end
      end
      StRun: begin
        if (!r_lk_s) w_state_d = StWaitLock;
      end
      default: w_state_d = StWaitLock;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_refclk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= StWaitLock;
      r_qual  <= '0;
    end else begin
      r_state <= w_state_d;
      r_qual  <= w_qual_d;
    end
  end

  // Config validation, restart decision and per-channel next counter/outputs
  always_comb begin
    w_ch_ok     = '0;
    w_phase_nxt = r_phase;
    w_cnt_d     = r_cnt;
    w_clk_d     = '0;
    w_stb_d     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_ch_ok[i] = (w_cfg_div[i] >= DIV_W'(2)) && (w_cfg_phase[i] < w_cfg_div[i]);
    end
    w_valid   = &w_ch_ok;
    w_accept  = i_cfg_load && w_valid;
    w_advance = (r_state == StRun) && (w_state_d == StRun);
    w_restart = (w_state_d == StRun) && ((r_state != StRun) || w_accept);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_accept) w_phase_nxt[i] = w_cfg_phase[i];
      if (w_restart) begin
        w_cnt_d[i] = w_phase_nxt[i];
      end else if (w_advance) begin
        w_cnt_d[i] = (r_cnt[i] == r_div[i] - DIV_W'(1)) ? '0 : r_cnt[i] + DIV_W'(1);
      end
      // Outputs follow the counter value held during the current cycle
      w_stb_d[i] = w_advance && i_ch_en[i] && (r_cnt[i] == r_div[i] - DIV_W'(1));
      w_clk_d[i] = w_advance && i_ch_en[i] && (r_cnt[i] < (r_div[i] >> 1));
    end
  end

  // Shadow configuration and sticky status flags
  always_ff @(posedge i_refclk or negedge i_rst) begin
    if (!i_rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_div[i]   <= DIV_W'(DEFAULT_DIV);
        r_phase[i] <= '0;
      end
      o_cfg_err   <= 1'b0;
      o_lock_lost <= 1'b0;
    end else begin
      if (i_cfg_load) o_cfg_err <= !w_valid;
      if (w_accept) begin
        r_div   <= w_cfg_div;
        r_phase <= w_cfg_phase;
      end
      if ((r_state == StRun) && (w_state_d != StRun)) o_lock_lost <= 1'b1;
    end
  end

  // Channel counters and registered outputs
  always_ff @(posedge i_refclk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt     <= '0;
      o_ready   <= 1'b0;
      o_clk_div <= '0;
      o_strobe  <= '0;
    end else begin
      r_cnt     <= w_cnt_d;
      o_ready   <= (w_state_d == StRun);
      o_clk_div <= w_clk_d;
      o_strobe  <= w_stb_d;
    end
  end

endmodule

// File: tb/tb_adc_clk_divider_bank.sv
// Randomised and directed bench for adc_clk_divider_bank with a timing model
// that predicts outputs from elapsed cycles since the last restart.
module tb_adc_clk_divider_bank;
  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int LC  = 16;

  logic              clk, rst, pll_locked, cfg_load;
  logic [NCH*DW-1:0] cfg_div, cfg_phase;
  logic [NCH-1:0]    ch_en;
  logic              o_ready, o_lock_lost, o_cfg_err;
  logic [NCH-1:0]    o_clk_div, o_strobe;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int n;
  bit m_s1, m_s2, m_run, m_lost, m_err;
  int streak, m_r;
  int sh_div[NCH];
  int sh_ph[NCH];

  adc_clk_divider_bank #(
    .NUM_CH(NCH), .DIV_W(DW), .LOCK_CYCLES(LC), .DEFAULT_DIV(10)
  ) u_dut (
    .i_refclk(clk), .i_rst(rst), .i_pll_locked(pll_locked),
    .i_cfg_div(cfg_div), .i_cfg_phase(cfg_phase), .i_cfg_load(cfg_load),
    .i_ch_en(ch_en), .o_ready(o_ready), .o_clk_div(o_clk_div),
    .o_strobe(o_strobe), .o_lock_lost(o_lock_lost), .o_cfg_err(o_cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_run = 0; m_lost = 0; m_err = 0;
    streak = 0; m_r = 0;
    for (int c = 0; c < NCH; c++) begin
      sh_div[c] = 10;
      sh_ph[c]  = 0;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear with no clock edge
  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_ready", {7'd0, o_ready}, 8'd0);
    chk("rst_clk", {6'd0, o_clk_div}, 8'd0);
    chk("rst_strobe", {6'd0, o_strobe}, 8'd0);
    chk("rst_lost", {7'd0, o_lock_lost}, 8'd0);
    chk("rst_err", {7'd0, o_cfg_err}, 8'd0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Advance one refclk edge, predicting outputs from the model first
  task automatic step();
    bit used, run_next, gate, valid;
    logic [NCH-1:0] e_clk, e_stb;
    int cv, d, p;
    n++;
    used = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_locked;
    if (m_run) begin
      run_next = used;
    end else begin
      streak   = used ? streak + 1 : 0;
      run_next = (streak == LC);
    end
    gate = m_run && run_next;
    for (int c = 0; c < NCH; c++) begin
      cv = (sh_ph[c] + (n - 1 - m_r)) % sh_div[c];
      e_stb[c] = gate && ch_en[c] && (cv == sh_div[c] - 1);
      e_clk[c] = gate && ch_en[c] && (cv < sh_div[c] / 2);
    end
    if (m_run && !used) m_lost = 1;
    valid = 1;
    for (int c = 0; c < NCH; c++) begin
      d = int'(cfg_div[c*DW +: DW]);
      p = int'(cfg_phase[c*DW +: DW]);
      if (d < 2 || p >= d) valid = 0;
    end
    if (cfg_load) begin
      m_err = !valid;
      if (valid) begin
        for (int c = 0; c < NCH; c++) begin
          sh_div[c] = int'(cfg_div[c*DW +: DW]);
          sh_ph[c]  = int'(cfg_phase[c*DW +: DW]);
        end
      end
    end
    if (run_next && (!m_run || (cfg_load && valid))) m_r = n;
    if (run_next) streak = 0;
    m_run = run_next;
    @(posedge clk);
    #1;
    chk("ready", {7'd0, o_ready}, {7'd0, run_next});
    chk("clk_div", {6'd0, o_clk_div}, {6'd0, e_clk});
    chk("strobe", {6'd0, o_strobe}, {6'd0, e_stb});
    chk("lock_lost", {7'd0, o_lock_lost}, {7'd0, m_lost});
    chk("cfg_err", {7'd0, o_cfg_err}, {7'd0, m_err});
  endtask

  task automatic load(int d0, int p0, int d1, int p1);
    cfg_div   = {DW'(d1), DW'(d0)};
    cfg_phase = {DW'(p1), DW'(p0)};
    cfg_load  = 1'b1;
    step();
    cfg_load  = 1'b0;
  endtask

  initial begin
    n = 0;
    rst = 1'b1; pll_locked = 1'b0; cfg_load = 1'b0; ch_en = '1;
    cfg_div = '0; cfg_phase = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Lock held high: ready exactly LC+2 edges after lock rises
    pll_locked = 1'b1;
    for (int k = 1; k <= LC + 1; k++) step();
    chk("ready_before_18", {7'd0, o_ready}, 8'd0);
    step();
    chk("ready_at_18", {7'd0, o_ready}, 8'd1);
    repeat (40) step();

    // One-cycle lock glitch during qualification
    do_reset();
    pll_locked = 1'b1;
    repeat (12) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    repeat (30) step();

    // Phase-offset restart, then odd divide
    load(4, 0, 4, 2);
    repeat (16) step();
    load(5, 0, 5, 1);
    repeat (15) step();

    // Rejected loads keep the running grid; a valid load clears the error
    load(5, 0, 1, 0);
    repeat (10) step();
    load(6, 6, 6, 0);
    repeat (10) step();
    load(10, 0, 10, 3);
    repeat (12) step();

    // Channel 0 gated for 7 cycles; the grid must be preserved
    ch_en = 2'b10;
    repeat (7) step();
    ch_en = 2'b11;
    repeat (20) step();

    // Randomised enables and configuration loads
    repeat (300) begin
      ch_en = NCH'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        cfg_div   = {DW'($urandom_range(1, 12)), DW'($urandom_range(1, 12))};
        cfg_phase = {DW'($urandom_range(0, 12)), DW'($urandom_range(0, 12))};
        cfg_load  = 1'b1;
      end
      step();
      cfg_load = 1'b0;
    end

    // Lock lost in RUN, config applied while unlocked, then relock
    ch_en = '1;
    pll_locked = 1'b0;
    repeat (4) step();
    load(3, 1, 7, 4);
    step();
    pll_locked = 1'b1;
    repeat (30) step();
    chk("lost_sticky", {7'd0, o_lock_lost}, 8'd1);

    // Asynchronous reset mid-run
    do_reset();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
